// File: rtl/spi_pkg.sv
// Shared definitions for spi_slave_mc: link states, SPI mode encodings and
// helpers that pick which SCLK edge samples MOSI and which one shifts MISO.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic {
    LINK_IDLE = 1'b0,
    LINK_SEL  = 1'b1
  } link_state_t;

  function automatic int cs_w(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

  function automatic logic sample_on_rise(input logic [1:0] mode);
    return (mode == SPI_MODE0) || (mode == SPI_MODE3);
  endfunction

  function automatic logic shift_on_rise(input logic [1:0] mode);
    return (mode == SPI_MODE1) || (mode == SPI_MODE2);
  endfunction

endpackage

// File: rtl/spi_slave_mc_sync.sv
// Two-flop synchroniser for one asynchronous SPI pin; a third flop provides
// registered rise/fall pulses aligned with the level output.
module spi_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] stg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg  <= '0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      stg  <= {stg[1:0], din};
      rise <= stg[1] & ~stg[2];
      fall <= ~stg[1] & stg[2];
    end
  end

  assign level = stg[2];

endmodule

// File: rtl/spi_slave_mc.sv
// spi_slave_mc: oversampling SPI slave with parametrised width, mode and chip selects.
// Define SPI_FRAME_ERR_EN to pulse frame_err when a chip select drops mid-word.
//
// state     | meaning
// LINK_IDLE | zero or several chip selects active; link ignored
// LINK_SEL  | exactly one chip select active; shifting enabled
module spi_slave_mc
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter bit CPOL = 1'b0,
  parameter bit CPHA = 1'b0,
  parameter logic [DATA_W-1:0] TX_IDLE = '0,
  localparam int CS_W = cs_w(NUM_CS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              mosi,
  input  logic [NUM_CS-1:0] cs_n,
  output logic              miso,
  output logic              miso_oe,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic [CS_W-1:0]   rx_cs,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam bit SAMPLE_RISE = sample_on_rise({CPOL, CPHA});
  localparam bit SHIFT_RISE  = shift_on_rise({CPOL, CPHA});

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic [NUM_CS-1:0] cs_act, cs_act_rise, cs_act_fall;

  spi_sync u_sync_sclk (.clk(clk), .rst(rst), .din(sclk), .level(sclk_lvl),
                        .rise(sclk_rise), .fall(sclk_fall));
  spi_sync u_sync_mosi (.clk(clk), .rst(rst), .din(mosi), .level(mosi_lvl),
                        .rise(mosi_rise), .fall(mosi_fall));

  // Chip selects are synchronised in active-high form so a reset sync chain reads as deselected.
  for (genvar i = 0; i < NUM_CS; i++) begin : g_cs
    spi_sync u_sync_cs (.clk(clk), .rst(rst), .din(~cs_n[i]), .level(cs_act[i]),
                        .rise(cs_act_rise[i]), .fall(cs_act_fall[i]));
  end

  logic sync_unused;
  assign sync_unused = ^{sclk_lvl, mosi_rise, mosi_fall, cs_act_rise, cs_act_fall};

  logic sel, sel_edge, desel_edge;
  logic [CS_W-1:0] cs_idx;
  logic sample_pulse, shift_pulse, load, accept;
  link_state_t state, state_nxt;

  assign sel          = $onehot(cs_act);
  assign sample_pulse = sel && (SAMPLE_RISE ? sclk_rise : sclk_fall);
  assign shift_pulse  = sel && (SHIFT_RISE ? sclk_rise : sclk_fall);

  always_comb begin
    cs_idx = '0;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_act[i]) cs_idx = CS_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LINK_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sel_edge   = 1'b0;
    desel_edge = 1'b0;
    case (state)
      LINK_IDLE: if (sel) begin
        state_nxt = LINK_SEL;
        sel_edge  = 1'b1;
      end
      LINK_SEL: if (!sel) begin
        state_nxt  = LINK_IDLE;
        desel_edge = 1'b1;
      end
      default: state_nxt = LINK_IDLE;
    endcase
  end

  logic [DATA_W-1:0] rx_shift, tx_shift, hold;
  logic [CNT_W-1:0]  bit_cnt;
  logic              hold_full;

  assign load     = (shift_pulse && (bit_cnt == '0)) || (!CPHA && sel_edge);
  assign tx_ready = ~hold_full;
  assign accept   = tx_valid && tx_ready;
  assign miso     = tx_shift[DATA_W-1];
  assign miso_oe  = sel;
  assign busy     = sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_shift    <= '0;
      rx_data     <= '0;
      rx_cs       <= '0;
      rx_valid    <= 1'b0;
      bit_cnt     <= '0;
      tx_shift    <= '0;
      tx_underrun <= 1'b0;
      hold        <= '0;
      hold_full   <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (!sel) begin
        bit_cnt <= '0;
      end else if (sample_pulse) begin
        rx_shift <= {rx_shift[DATA_W-2:0], mosi_lvl};
        if (bit_cnt == LAST_BIT) begin
          rx_data  <= {rx_shift[DATA_W-2:0], mosi_lvl};
          rx_cs    <= cs_idx;
          rx_valid <= 1'b1;
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      // A word accepted in the same cycle as a load waits for the next load.
      if (load) begin
        if (hold_full) begin
          tx_shift <= hold;
        end else begin
          tx_shift    <= TX_IDLE;
          tx_underrun <= 1'b1;
        end
      end else if (shift_pulse) begin
        tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      end
      if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

`ifdef SPI_FRAME_ERR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= desel_edge && (bit_cnt != '0);
  end
`else
  logic frame_unused;
  assign frame_unused = desel_edge;
  assign frame_err    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_mc.sv
// Scoreboard bench for spi_slave_mc: three instances in modes 0, 3 and 1 driven by a bit-banged host.
module tb_spi_slave_mc;

  localparam int HALF = 100;

  typedef struct packed {
    logic [1:0] u;
    logic [7:0] d;
    logic       c;
  } rx_exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk [3];
  logic       mosi [3];
  logic [1:0] cs_n [3];
  logic       miso [3];
  logic       miso_oe [3];
  logic       rx_valid [3];
  logic [7:0] rx_data [3];
  logic [0:0] rx_cs [3];
  logic       tx_valid [3];
  logic [7:0] tx_data [3];
  logic       tx_ready [3];
  logic       tx_underrun [3];
  logic       frame_err [3];
  logic       busy [3];

  int n_vec = 0;
  int n_bad = 0;
  int und_cnt [3];
  int ferr_cnt [3];
  rx_exp_t exp_q[$];

  always #5 clk = ~clk;

  spi_slave_mc #(.DATA_W(8), .NUM_CS(2), .CPOL(1'b0), .CPHA(1'b0), .TX_IDLE(8'h00)) u0 (
    .clk(clk), .rst(rst), .sclk(sclk[0]), .mosi(mosi[0]), .cs_n(cs_n[0]), .miso(miso[0]),
    .miso_oe(miso_oe[0]), .rx_valid(rx_valid[0]), .rx_data(rx_data[0]), .rx_cs(rx_cs[0]),
    .tx_valid(tx_valid[0]), .tx_data(tx_data[0]), .tx_ready(tx_ready[0]),
    .tx_underrun(tx_underrun[0]), .frame_err(frame_err[0]), .busy(busy[0]));

  spi_slave_mc #(.DATA_W(8), .NUM_CS(2), .CPOL(1'b1), .CPHA(1'b1), .TX_IDLE(8'h00)) u1 (
    .clk(clk), .rst(rst), .sclk(sclk[1]), .mosi(mosi[1]), .cs_n(cs_n[1]), .miso(miso[1]),
    .miso_oe(miso_oe[1]), .rx_valid(rx_valid[1]), .rx_data(rx_data[1]), .rx_cs(rx_cs[1]),
    .tx_valid(tx_valid[1]), .tx_data(tx_data[1]), .tx_ready(tx_ready[1]),
    .tx_underrun(tx_underrun[1]), .frame_err(frame_err[1]), .busy(busy[1]));

  spi_slave_mc #(.DATA_W(8), .NUM_CS(2), .CPOL(1'b0), .CPHA(1'b1), .TX_IDLE(8'hFF)) u2 (
    .clk(clk), .rst(rst), .sclk(sclk[2]), .mosi(mosi[2]), .cs_n(cs_n[2]), .miso(miso[2]),
    .miso_oe(miso_oe[2]), .rx_valid(rx_valid[2]), .rx_data(rx_data[2]), .rx_cs(rx_cs[2]),
    .tx_valid(tx_valid[2]), .tx_data(tx_data[2]), .tx_ready(tx_ready[2]),
    .tx_underrun(tx_underrun[2]), .frame_err(frame_err[2]), .busy(busy[2]));

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endfunction

  // Monitor: pops the scoreboard on every rx_valid and counts status pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tx_underrun[i]) und_cnt[i]++;
      if (frame_err[i]) ferr_cnt[i]++;
      if (rx_valid[i]) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL rx_unexpected unit=%0d got=%0h required=none", i, rx_data[i]);
        end else begin
          rx_exp_t e;
          e = exp_q.pop_front();
          check("rx_unit", i, e.u);
          check("rx_data", rx_data[i], e.d);
          check("rx_cs", rx_cs[i], e.c);
        end
      end
    end
  end

  task automatic push_tx(input int u, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    tx_data[u]  = d;
    tx_valid[u] = 1'b1;
    while (!tx_ready[u] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL tx_ready_timeout unit=%0d got=0 required=1", u);
    end
    @(posedge clk);
    #1 tx_valid[u] = 1'b0;
    @(negedge clk);
    check("tx_ready_fall", tx_ready[u], 1'b0);
  endtask

  task automatic spi_bits(input int u, input logic cpol, input logic cpha,
                          input logic [7:0] d, input int nbits, output logic [7:0] got);
    got = '0;
    for (int b = 0; b < nbits; b++) begin
      if (!cpha) begin
        mosi[u] = d[7-b];
        #HALF sclk[u] = ~cpol;
        got = {got[6:0], miso[u]};
        #HALF sclk[u] = cpol;
      end else begin
        sclk[u] = ~cpol;
        mosi[u] = d[7-b];
        #HALF sclk[u] = cpol;
        got = {got[6:0], miso[u]};
        #HALF;
      end
    end
  endtask

  task automatic select(input int u, input logic [1:0] c);
    cs_n[u] = c;
    #HALF;
  endtask

  task automatic deselect(input int u);
    #HALF cs_n[u] = 2'b11;
    #HALF;
  endtask

  initial begin
    #1ms;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] got;
    int und0, ferr0, frame_req;
    for (int i = 0; i < 3; i++) begin
      sclk[i] = (i == 1);
      mosi[i] = 1'b0;
      cs_n[i] = 2'b11;
      tx_valid[i] = 1'b0;
      tx_data[i] = '0;
      und_cnt[i] = 0;
      ferr_cnt[i] = 0;
    end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_miso", miso[i], 1'b0);
      check("rst_miso_oe", miso_oe[i], 1'b0);
      check("rst_busy", busy[i], 1'b0);
      check("rst_tx_ready", tx_ready[i], 1'b1);
      check("rst_rx_data", rx_data[i], 8'h00);
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Mode 0: preloaded 0x3C out, 0xA5 in on cs0; trailing edge after last bit underruns.
    push_tx(0, 8'h3C);
    und0 = und_cnt[0];
    select(0, 2'b10);
    check("m0_busy", busy[0], 1'b1);
    check("m0_miso_oe", miso_oe[0], 1'b1);
    exp_q.push_back('{u: 2'd0, d: 8'hA5, c: 1'b0});
    spi_bits(0, 1'b0, 1'b0, 8'hA5, 8, got);
    check("m0_miso_word", got, 8'h3C);
    deselect(0);
    check("m0_underruns", und_cnt[0] - und0, 1);
    check("m0_tx_ready", tx_ready[0], 1'b1);
    check("m0_busy_off", busy[0], 1'b0);

    // Mode 3: two back-to-back words on cs1, only 0xF0 preloaded.
    push_tx(1, 8'hF0);
    und0 = und_cnt[1];
    select(1, 2'b01);
    exp_q.push_back('{u: 2'd1, d: 8'h12, c: 1'b1});
    spi_bits(1, 1'b1, 1'b1, 8'h12, 8, got);
    check("m3_miso_word1", got, 8'hF0);
    exp_q.push_back('{u: 2'd1, d: 8'h34, c: 1'b1});
    spi_bits(1, 1'b1, 1'b1, 8'h34, 8, got);
    check("m3_miso_word2", got, 8'h00);
    deselect(1);
    check("m3_underruns", und_cnt[1] - und0, 1);

    // Mode 1 with TX_IDLE=0xFF and nothing queued.
    und0 = und_cnt[2];
    select(2, 2'b10);
    exp_q.push_back('{u: 2'd2, d: 8'h6B, c: 1'b0});
    spi_bits(2, 1'b0, 1'b1, 8'h6B, 8, got);
    check("m1_miso_idle", got, 8'hFF);
    deselect(2);
    check("m1_underruns", und_cnt[2] - und0, 1);

    // Chip select dropped after 5 bits, then a clean word.
`ifdef SPI_FRAME_ERR_EN
    frame_req = 1;
`else
    frame_req = 0;
`endif
    ferr0 = ferr_cnt[0];
    select(0, 2'b10);
    spi_bits(0, 1'b0, 1'b0, 8'hC3, 5, got);
    deselect(0);
    check("frame_err_pulses", ferr_cnt[0] - ferr0, frame_req);
    select(0, 2'b10);
    exp_q.push_back('{u: 2'd0, d: 8'h81, c: 1'b0});
    spi_bits(0, 1'b0, 1'b0, 8'h81, 8, got);
    check("after_abort_miso", got, 8'h00);
    deselect(0);
    check("after_abort_frame_err", ferr_cnt[0] - ferr0, frame_req);

    // Both chip selects low: link stays deselected.
    select(0, 2'b00);
    check("dual_cs_miso_oe", miso_oe[0], 1'b0);
    check("dual_cs_busy", busy[0], 1'b0);
    spi_bits(0, 1'b0, 1'b0, 8'hFF, 8, got);
    deselect(0);

    // Reset in the middle of a word with a word waiting in the holding register.
    select(0, 2'b10);
    spi_bits(0, 1'b0, 1'b0, 8'h5A, 4, got);
    push_tx(0, 8'h99);
    rst = 1'b1;
    #1;
    check("midrst_miso", miso[0], 1'b0);
    check("midrst_miso_oe", miso_oe[0], 1'b0);
    check("midrst_busy", busy[0], 1'b0);
    check("midrst_rx_data", rx_data[0], 8'h00);
    check("midrst_rx_valid", rx_valid[0], 1'b0);
    check("midrst_tx_ready", tx_ready[0], 1'b1);
    cs_n[0] = 2'b11;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    select(0, 2'b10);
    exp_q.push_back('{u: 2'd0, d: 8'h5A, c: 1'b0});
    spi_bits(0, 1'b0, 1'b0, 8'h5A, 8, got);
    check("post_rst_miso", got, 8'h00);
    deselect(0);

    for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge clk);
    check("rx_queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
